// File: rtl/si_pkg.sv
// Shared definitions for the game datapath: collision detector state
// encoding and raster constants.
package si_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SCAN       = 2'd1,
        REPORT     = 2'd2
    } cd_state_e;

    // Default enemy index width (up to 64 enemies).
    localparam int ENEMY_ID_W = 6;

    // Raster position of the frame strobe, outside the active area.
    localparam int FRAME_X = 2;
    localparam int FRAME_Y = 481;

endpackage

// File: rtl/overlap_counter.sv
// Saturating overlap counter: counts qualified overlap pixels up to max_p
// and flags saturation, which is the per-frame "hit" condition.
module overlap_counter #(
    parameter int unsigned max_p = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam int unsigned CountW = $clog2(max_p + 1);

    logic [CountW-1:0] r_count;

    // Count overlap pixels, holding at max_p once reached.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset_i || clear_i) begin
            r_count <= '0;
        end else if (inc_i && !hit_o) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign hit_o = (r_count == CountW'(max_p));

endmodule

// File: rtl/collision_detector.sv
// Per-frame collision detector: accumulates overlaps during the active
// raster, issues one-cycle hit pulses after each frame strobe and runs the
// player's post-hit invulnerability window.
module collision_detector
    import si_pkg::*;
#(
    parameter int unsigned enemy_id_width_p  = ENEMY_ID_W,
    parameter int unsigned min_overlap_p     = 2,
    parameter int unsigned cooldown_frames_p = 60
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        frame_i,
    input  logic                        de_i,
    input  logic                        player_px_i,
    input  logic                        player_bullet_px_i,
    input  logic                        enemy_px_i,
    input  logic [enemy_id_width_p-1:0] enemy_id_i,
    input  logic                        enemy_bullet_px_i,
    output logic                        hit_enemy_o,
    output logic [enemy_id_width_p-1:0] hit_enemy_id_o,
    output logic                        hit_player_o,
    output logic                        bullet_consume_o,
    output logic                        invuln_o
);

    cd_state_e r_state;
    cd_state_e w_next_state;

    logic w_count_en;
    logic w_inc_pe;
    logic w_inc_pp;
    logic w_inc_bb;
    logic w_clear;
    logic w_eval;
    logic w_pe_hit;
    logic w_pp_hit;
    logic w_bb_hit;

    logic w_hit_enemy;
    logic w_hit_player;
    logic w_consume;

    logic                        r_cand_valid;
    logic [enemy_id_width_p-1:0] r_cand_id;
    logic [7:0]                  r_cooldown;
    logic [7:0]                  w_cooldown_next;

    logic                        r_hit_enemy;
    logic [enemy_id_width_p-1:0] r_hit_enemy_id;
    logic                        r_hit_player;
    logic                        r_consume;

    // Pixel qualification: only active-video pixels while scanning count.
    assign w_count_en = (r_state == SCAN) && de_i && !frame_i;
    assign w_inc_pe   = w_count_en && player_bullet_px_i && enemy_px_i;
    assign w_inc_pp   = w_count_en && enemy_bullet_px_i && player_px_i && !invuln_o;
    assign w_inc_bb   = w_count_en && player_bullet_px_i && enemy_bullet_px_i;
    assign w_clear    = (r_state == REPORT);
    assign w_eval     = (r_state == SCAN) && frame_i;

    overlap_counter #(.max_p(min_overlap_p)) u_pe_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(w_clear),
        .inc_i  (w_inc_pe),
        .hit_o  (w_pe_hit)
    );

    overlap_counter #(.max_p(min_overlap_p)) u_pp_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(w_clear),
        .inc_i  (w_inc_pp),
        .hit_o  (w_pp_hit)
    );

    overlap_counter #(.max_p(min_overlap_p)) u_bb_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(w_clear),
        .inc_i  (w_inc_bb),
        .hit_o  (w_bb_hit)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= WAIT_FRAME;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: first strobe syncs to the raster, later strobes report.
    always_comb begin
        // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            WAIT_FRAME: if (frame_i) w_next_state = SCAN;
            SCAN:       if (frame_i) w_next_state = REPORT;
            REPORT:     w_next_state = SCAN;
            default:    w_next_state = WAIT_FRAME;
        endcase
    end

    // Output decode: pulse values evaluated at the strobe that ends a scan.
    always_comb begin
        w_hit_enemy  = w_eval && w_pe_hit;
        w_hit_player = w_eval && w_pp_hit;
        w_consume    = w_eval && (w_pe_hit || w_bb_hit);
    end

    // Latch the first player-bullet/enemy overlap of the frame in raster order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cand_valid <= 1'b0;
            r_cand_id    <= '0;
        end else if (w_clear) begin
            r_cand_valid <= 1'b0;
        end else if (w_inc_pe && !r_cand_valid) begin
            r_cand_valid <= 1'b1;
            r_cand_id    <= enemy_id_i;
        end
    end

    // Cooldown next value: a player hit reload wins over the per-frame decrement.
    always_comb begin
        w_cooldown_next = r_cooldown;
        if (w_hit_player) begin
            w_cooldown_next = 8'(cooldown_frames_p);
        end else if (frame_i && (r_cooldown != 8'd0)) begin
            w_cooldown_next = r_cooldown - 8'd1;
        end
    end

    // Cooldown register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cooldown <= 8'd0;
        end else begin
            r_cooldown <= w_cooldown_next;
        end
    end

    // Registered pulse outputs; the enemy index holds until the next enemy hit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_hit_enemy    <= 1'b0;
            r_hit_enemy_id <= '0;
            r_hit_player   <= 1'b0;
            r_consume      <= 1'b0;
        end else begin
            r_hit_enemy  <= w_hit_enemy;
            r_hit_player <= w_hit_player;
            r_consume    <= w_consume;
            if (w_hit_enemy) begin
                r_hit_enemy_id <= r_cand_id;
            end
        end
    end

    assign hit_enemy_o      = r_hit_enemy;
    assign hit_enemy_id_o   = r_hit_enemy_id;
    assign hit_player_o     = r_hit_player;
    assign bullet_consume_o = r_consume;
    assign invuln_o         = (r_cooldown != 8'd0);

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: directed frame table,
// cooldown and reset sequences, then random frames against a frame-level model.
module tb_collision_detector;

    localparam int MIN  = 2;
    localparam int COOL = 60;

    logic       clk_i;
    logic       reset_i;
    logic       frame_i;
    logic       de_i;
    logic       player_px_i;
    logic       player_bullet_px_i;
    logic       enemy_px_i;
    logic [5:0] enemy_id_i;
    logic       enemy_bullet_px_i;
    logic       hit_enemy_o;
    logic [5:0] hit_enemy_id_o;
    logic       hit_player_o;
    logic       bullet_consume_o;
    logic       invuln_o;

    collision_detector #(
        .enemy_id_width_p (6),
        .min_overlap_p    (MIN),
        .cooldown_frames_p(COOL)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .frame_i           (frame_i),
        .de_i              (de_i),
        .player_px_i       (player_px_i),
        .player_bullet_px_i(player_bullet_px_i),
        .enemy_px_i        (enemy_px_i),
        .enemy_id_i        (enemy_id_i),
        .enemy_bullet_px_i (enemy_bullet_px_i),
        .hit_enemy_o       (hit_enemy_o),
        .hit_enemy_id_o    (hit_enemy_id_o),
        .hit_player_o      (hit_player_o),
        .bullet_consume_o  (bullet_consume_o),
        .invuln_o          (invuln_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       de;
        logic       pb;
        logic       en;
        logic       eb;
        logic       pl;
        logic [5:0] id;
    } pix_t;

    typedef struct {
        int he;
        int id;
        int hp;
        int bc;
        int inv;
    } exp_t;

    typedef struct {
        string name;
        int    pe_a;
        int    id_a;
        int    pe_b;
        int    id_b;
        int    pp;
        int    bb;
        exp_t  e;
    } vec_t;

    pix_t frame_q[$];

    int checks   = 0;
    int failures = 0;

    // Frame-level reference state.
    int         m_cd     = 0;
    logic       m_synced = 1'b0;
    logic [5:0] m_id     = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        frame_i            = 1'b0;
        de_i               = 1'b0;
        player_px_i        = 1'b0;
        player_bullet_px_i = 1'b0;
        enemy_px_i         = 1'b0;
        enemy_id_i         = '0;
        enemy_bullet_px_i  = 1'b0;
    endtask

    function automatic void push_pix(input logic de, input logic pb, input logic en,
                                     input logic eb, input logic pl, input logic [5:0] id);
        pix_t p;
        p.de = de; p.pb = pb; p.en = en; p.eb = eb; p.pl = pl; p.id = id;
        frame_q.push_back(p);
    endfunction

    // Frame layout: an ignored blanking pixel with every flag set, then groups
    // of overlap pixels separated by empty active pixels.
    task automatic build_frame(input int pe_a, input int id_a, input int pe_b, input int id_b,
                               input int pp, input int bb);
        frame_q.delete();
        push_pix(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd63);
        for (int i = 0; i < pe_a; i++) push_pix(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'(id_a));
        push_pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < pe_b; i++) push_pix(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'(id_b));
        push_pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < pp; i++) push_pix(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0);
        push_pix(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < bb; i++) push_pix(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
    endtask

    task automatic build_random_frame();
        int n;
        frame_q.delete();
        n = $urandom_range(8, 30);
        for (int i = 0; i < n; i++) begin
            push_pix($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0, 6'($urandom_range(0, 63)));
        end
    endtask

    // Reference: count the frame's qualified overlaps and apply the hit,
    // first-id and cooldown rules for the strobe that ends it.
    task automatic model_frame(output exp_t e);
        int   pe = 0;
        int   pp = 0;
        int   bb = 0;
        logic got_first = 1'b0;
        logic [5:0] first_id = '0;
        foreach (frame_q[i]) begin
            if (frame_q[i].de) begin
                if (frame_q[i].pb && frame_q[i].en) begin
                    pe++;
                    if (!got_first) begin
                        got_first = 1'b1;
                        first_id  = frame_q[i].id;
                    end
                end
                if (frame_q[i].eb && frame_q[i].pl && m_cd == 0) pp++;
                if (frame_q[i].pb && frame_q[i].eb) bb++;
            end
        end
        e.he = 0; e.hp = 0; e.bc = 0;
        if (m_synced) begin
            e.he = (pe >= MIN) ? 1 : 0;
            e.hp = (pp >= MIN) ? 1 : 0;
            e.bc = (e.he == 1 || bb >= MIN) ? 1 : 0;
            if (e.he == 1) m_id = first_id;
        end
        if (e.hp == 1)     m_cd = COOL;
        else if (m_cd > 0) m_cd = m_cd - 1;
        m_synced = 1'b1;
        e.id  = int'(m_id);
        e.inv = (m_cd != 0) ? 1 : 0;
    endtask

    task automatic model_reset();
        m_cd     = 0;
        m_synced = 1'b0;
        m_id     = '0;
    endtask

    task automatic apply_pixels();
        foreach (frame_q[i]) begin
            de_i               = frame_q[i].de;
            player_bullet_px_i = frame_q[i].pb;
            enemy_px_i         = frame_q[i].en;
            enemy_bullet_px_i  = frame_q[i].eb;
            player_px_i        = frame_q[i].pl;
            enemy_id_i         = frame_q[i].id;
            tick();
        end
        idle_inputs();
    endtask

    task automatic strobe_check(input string name, input exp_t e);
        idle_inputs();
        tick();
        tick();
        check({name, "_quiet"}, int'({hit_enemy_o, hit_player_o, bullet_consume_o}), 0);
        frame_i = 1'b1;
        tick();
        frame_i = 1'b0;
        check({name, "_hit_enemy"},   int'(hit_enemy_o),      e.he);
        check({name, "_enemy_id"},    int'(hit_enemy_id_o),   e.id);
        check({name, "_hit_player"},  int'(hit_player_o),     e.hp);
        check({name, "_consume"},     int'(bullet_consume_o), e.bc);
        check({name, "_invuln"},      int'(invuln_o),         e.inv);
        tick();
        check({name, "_pulse_end"},   int'({hit_enemy_o, hit_player_o, bullet_consume_o}), 0);
        check({name, "_invuln_hold"}, int'(invuln_o),         e.inv);
    endtask

    task automatic run_frame(input string name, input logic use_ovr, input exp_t ovr);
        exp_t m;
        model_frame(m);
        apply_pixels();
        strobe_check(name, use_ovr ? ovr : m);
    endtask

    vec_t tbl[10];
    exp_t no_ovr;
    exp_t ex;

    initial begin
        tbl[0] = '{"after_reset_ignored", 5, 17, 0, 0, 0, 0, '{0,  0, 0, 0, 0}};
        tbl[1] = '{"pe5_id17",            5, 17, 0, 0, 0, 0, '{1, 17, 0, 1, 0}};
        tbl[2] = '{"pe1_below_min",       1, 30, 0, 0, 0, 0, '{0, 17, 0, 0, 0}};
        tbl[3] = '{"pe2_id5",             2,  5, 0, 0, 0, 0, '{1,  5, 0, 1, 0}};
        tbl[4] = '{"pe_first_id_wins",    2,  3, 2, 9, 0, 0, '{1,  3, 0, 1, 0}};
        tbl[5] = '{"bb_plus_pe",          2, 12, 0, 0, 0, 2, '{1, 12, 0, 1, 0}};
        tbl[6] = '{"bb_alone",            0,  0, 0, 0, 0, 3, '{0, 12, 0, 1, 0}};
        tbl[7] = '{"bb1_below_min",       0,  0, 0, 0, 0, 1, '{0, 12, 0, 0, 0}};
        tbl[8] = '{"pp1_below_min",       0,  0, 0, 0, 1, 0, '{0, 12, 0, 0, 0}};
        tbl[9] = '{"pp4_hit",             0,  0, 0, 0, 4, 0, '{0, 12, 1, 0, 1}};
        no_ovr = '{0, 0, 0, 0, 0};

        idle_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        model_reset();
        check("reset_outputs",
              int'({hit_enemy_o, hit_player_o, bullet_consume_o, invuln_o}), 0);
        check("reset_enemy_id", int'(hit_enemy_id_o), 0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            build_frame(tbl[i].pe_a, tbl[i].id_a, tbl[i].pe_b, tbl[i].id_b,
                        tbl[i].pp, tbl[i].bb);
            run_frame(tbl[i].name, 1'b1, tbl[i].e);
        end

        // Invulnerability window: player overlap every frame is ignored until
        // the 60th strobe clears the window, then the next frame hits again.
        for (int k = 1; k <= 61; k++) begin
            ex = '{0, 12, (k == 61) ? 1 : 0, 0, (k < 60 || k == 61) ? 1 : 0};
            build_frame(0, 0, 0, 0, 4, 0);
            run_frame($sformatf("cooldown_f%0d", k), 1'b1, ex);
        end

        // Reset in mid-scan with overlaps pending and the window active.
        build_frame(3, 7, 0, 0, 0, 0);
        apply_pixels();
        de_i = 1'b1; player_bullet_px_i = 1'b1; enemy_px_i = 1'b1; enemy_id_i = 6'd7;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        idle_inputs();
        model_reset();
        check("midscan_reset_outputs",
              int'({hit_enemy_o, hit_player_o, bullet_consume_o, invuln_o}), 0);
        check("midscan_reset_id", int'(hit_enemy_id_o), 0);
        build_frame(3, 7, 0, 0, 0, 0);
        run_frame("post_reset_partial", 1'b1, '{0, 0, 0, 0, 0});
        build_frame(2, 21, 0, 0, 0, 0);
        run_frame("post_reset_pe2_id21", 1'b1, '{1, 21, 0, 1, 0});

        // Random frames against the reference model.
        for (int f = 0; f < 200; f++) begin
            build_random_frame();
            run_frame($sformatf("rand_f%0d", f), 1'b0, no_ovr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collision_detector.md
# collision_detector

Per-frame hit detector for the game datapath. It samples the per-pixel coverage flags for player, player bullet, enemies and enemy bullets during the active raster, and accumulates overlaps. At each frame strobe it issues one-cycle hit pulses, which feed the player block's `hit_i` and `hit_enemy_i` inputs and the enemy formation's kill input. It sits between the per-pixel area logic and the game-state blocks, and it also runs the player's post-hit invulnerability window.

## Interface
Parameters:
- `enemy_id_width_p`, 6, width of enemy index (up to 64 enemies)
- `min_overlap_p`, 2, overlapping pixels per frame required to register a hit (1..15)
- `cooldown_frames_p`, 60, frames of player invulnerability after a player hit (1..255)

Ports:
- `clk_i` in 1: pixel clock; the only clock
- `reset_i` in 1: synchronous, active-high reset
- `frame_i` in 1: one-cycle strobe once per frame, outside the active area (y=481, x=2)
- `de_i` in 1: active-video qualifier
- `player_px_i` in 1: current pixel lies inside the player ship
- `player_bullet_px_i` in 1: current pixel lies inside the player bullet
- `enemy_px_i` in 1: current pixel lies inside an enemy
- `enemy_id_i` in `enemy_id_width_p`: index of that enemy; valid only when `enemy_px_i`=1
- `enemy_bullet_px_i` in 1: current pixel lies inside any enemy bullet
- `hit_enemy_o` out 1: one-cycle pulse, an enemy was hit this frame
- `hit_enemy_id_o` out `enemy_id_width_p`: index of the hit enemy; held until the next `hit_enemy_o`
- `hit_player_o` out 1: one-cycle pulse, the player was hit
- `bullet_consume_o` out 1: one-cycle pulse, the player bullet must be retired
- `invuln_o` out 1: high while the cooldown is nonzero

## Operation
- Reset values: all outputs 0; state WAIT_FRAME; counters 0; cooldown 0.
- WAIT_FRAME: pixel inputs are ignored, so a partial frame after reset is discarded. `frame_i` moves the block to SCAN.
- SCAN: a pixel counts only when `de_i`=1 and `frame_i`=0. Three saturating counters, each saturating at `min_overlap_p`:
  - `pe`: `player_bullet_px_i` AND `enemy_px_i`
  - `pp`: `enemy_bullet_px_i` AND `player_px_i` AND `invuln_o`=0
  - `bb`: `player_bullet_px_i` AND `enemy_bullet_px_i`
- Enemy id capture: on the first `pe` pixel of a frame (first in raster order), `enemy_id_i` is latched into a candidate register. Later `pe` pixels in the same frame do not overwrite it.
- `frame_i` in SCAN: evaluate the counters, then go to REPORT.
- REPORT lasts exactly one cycle, then returns to SCAN:
  - `hit_enemy_o` = (`pe`==`min_overlap_p`); `hit_enemy_id_o` is loaded from the candidate register.
  - `hit_player_o` = (`pp`==`min_overlap_p`).
  - `bullet_consume_o` = `hit_enemy_o` OR (`bb`==`min_overlap_p`). It pulses once even when both conditions hold.
  - Counters and the candidate-valid flag clear.
  - Pixels arriving in this cycle are not counted; `de_i` is 0 here anyway.
- Cooldown:
  - `hit_player_o` loads the cooldown with `cooldown_frames_p`.
  - Otherwise each `frame_i` decrements it while nonzero.
  - `invuln_o` = (cooldown != 0).
  - A load and a decrement in the same frame resolve to the load.
- Simultaneous events: enemy hit and player hit in the same frame produce both pulses. Reset at any point returns to WAIT_FRAME, clears the cooldown and drops any pending report.

## Timing
- `frame_i` sampled high at edge N: REPORT occupies cycle N..N+1, and the pulse outputs are high for exactly that one cycle.
- Pixel at cycle k is counted at edge k+1. The evaluation at edge N includes every pixel up to cycle N-1.
- Latency from the last overlapping pixel to the pulse is at most one frame.
- `invuln_o` rises at the same edge as `hit_player_o` and falls at the edge of the `cooldown_frames_p`-th subsequent `frame_i`.
- All outputs are registered; there are no combinational input-to-output paths.
- Counter width is $clog2(`min_overlap_p`+1). The cooldown counter is 8 bits.

## Structure
- Shared package `si_pkg`:
  - enum `cd_state_e` {WAIT_FRAME, SCAN, REPORT}
  - `ENEMY_ID_W` = 6
  - `FRAME_X` = 2, `FRAME_Y` = 481
- Sub-module `overlap_counter`: a saturating counter with `clear_i` and `inc_i`, and a `hit_o` flag that goes high at saturation. It is instantiated three times.

## Test plan
- After reset, `pe` overlap of 5 pixels with `enemy_id_i`=17 before the first `frame_i` -> no pulse at the first strobe. The same overlap in the next frame -> `hit_enemy_o` and `bullet_consume_o` pulse one cycle after `frame_i`, with `hit_enemy_id_o`=17.
- Single-pixel `pe` overlap with `min_overlap_p`=2 -> no pulse. Two pixels -> pulse.
- `pe` overlap on enemy 3 and then enemy 9 in the same frame -> `hit_enemy_id_o`=3 and exactly one `hit_enemy_o`.
- `pp` overlap of 4 pixels -> `hit_player_o` pulse and `invuln_o`=1. Repeated `pp` for the next 60 frames -> no pulse. `invuln_o` falls at the 60th `frame_i`; `pp` in frame 61 -> pulse.
- `bb` plus `pe` in the same frame -> `bullet_consume_o` high for exactly 1 cycle. `bb` alone -> `bullet_consume_o` pulses with `hit_enemy_o`=0.
- `reset_i` asserted during SCAN with `pe` counts pending -> no pulse at the next `frame_i`, outputs 0, `invuln_o`=0.
